// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with a bounded grant hold time.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_EN         arbiter enable; dropping it ends any active grant
//   i_req        request vector, bit k = requester k (2**N requesters)
//   i_release    current owner is done; only looked at while a grant is active
//   o_gnt_valid  a grant is active
//   o_gnt_idx    binary index of the current (or most recent) owner
//   o_Y          one-hot grant, all zero whenever o_gnt_valid is low
//   o_timeout    one-cycle pulse after a grant was revoked by the hold limit
//
// Every grant is followed by at least one idle cycle, so successive owners
// always see a one-cycle gap. The search pointer moves to the slot just past
// each winner, which gives the round-robin order.
module rr_grant_arbiter #(
   parameter  int unsigned N        = 2,
   parameter  int unsigned MAX_HOLD = 8,
   localparam int unsigned NREQ     = 1 << N
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_EN,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_release,
   output logic            o_gnt_valid,
   output logic [N-1:0]    o_gnt_idx,
   output logic [NREQ-1:0] o_Y,
   output logic            o_timeout
);

   // Hold counter is wide enough for the full legal MAX_HOLD range (1..255)
   localparam int unsigned       HOLD_W    = 8;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                gnt_valid_d;
   logic [N-1:0]        gnt_idx_d;
   logic                timeout_d;

   logic                win_found;
   logic [N-1:0]        win_idx;
   logic [N-1:0]        cand;

   logic                early_exit;
   logic                hold_limit;

   // Winner search: first set request at or above ptr, wrapping past the top
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = ptr_q + N'(i);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Release, owner drop and disable all outrank the hold limit
   assign early_exit = i_release | ~i_req[o_gnt_idx] | ~i_EN;
   assign hold_limit = (hold_q == HOLD_LAST);

   // Next-state and registered-output values
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_valid_d = 1'b0;
      gnt_idx_d   = o_gnt_idx;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_EN && win_found) begin
               state_d     = GRANT;
               gnt_valid_d = 1'b1;
               gnt_idx_d   = win_idx;
               ptr_d       = win_idx + N'(1);
               hold_d      = '0;
            end
         end

         GRANT: begin
            gnt_valid_d = 1'b1;
            if (!hold_limit) begin
               hold_d = hold_q + HOLD_W'(1);
            end
            if (early_exit || hold_limit) begin
               state_d     = IDLE;
               gnt_valid_d = 1'b0;
               timeout_d   = hold_limit & ~early_exit;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         o_gnt_valid <= 1'b0;
         o_gnt_idx   <= '0;
         o_timeout   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         o_gnt_valid <= gnt_valid_d;
         o_gnt_idx   <= gnt_idx_d;
         o_timeout   <= timeout_d;
      end
   end

   // One-hot view of the grant, a pure decode of the grant registers
   always_comb begin
      o_Y = '0;
      if (o_gnt_valid) begin
         o_Y[o_gnt_idx] = 1'b1;
      end
   end

   // Structural invariants of the registered outputs
   a_y_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_Y));
   a_timeout_idle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_timeout |-> !o_gnt_valid);
   a_valid_state : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_gnt_valid == (state_q == GRANT));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter: directed scenarios followed by random traffic,
// all checked by a scoreboard fed from a behavioural model, plus a few direct
// spot checks against fixed expected values.
module tb_rr_grant_arbiter;

   localparam int N        = 2;
   localparam int NR       = 4;
   localparam int MAX_HOLD = 8;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b0;
   logic          rel   = 1'b0;
   logic [NR-1:0] req   = '0;

   logic          gnt_valid;
   logic [N-1:0]  gnt_idx;
   logic [NR-1:0] y;
   logic          timeout;

   rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_EN        (en),
      .i_req       (req),
      .i_release   (rel),
      .o_gnt_valid (gnt_valid),
      .o_gnt_idx   (gnt_idx),
      .o_Y         (y),
      .o_timeout   (timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [N-1:0]  idx;
      logic [NR-1:0] y;
      logic          to;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   own [5] = '{0, 1, 2, 3, 0};
   logic [NR-1:0] rnd_req = '0;

   // Reference model: granted flag, owner, pointer, cycles the grant has been visible
   bit m_gnt;
   int m_owner;
   int m_ptr;
   int m_held;
   bit m_to;

   function automatic void model_reset();
      m_gnt   = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
   endfunction

   function automatic void model_step();
      bit early;
      bit lim;
      int c;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_to = 1'b0;
      if (m_gnt) begin
         early = rel || !req[m_owner] || !en;
         lim   = (m_held == MAX_HOLD);
         if (early || lim) begin
            m_gnt = 1'b0;
            m_to  = lim && !early;
         end else begin
            m_held++;
         end
      end else if (en && req != '0) begin
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (req[c]) begin
               m_owner = c;
               break;
            end
         end
         m_ptr  = (m_owner + 1) % NR;
         m_gnt  = 1'b1;
         m_held = 1;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.v   = m_gnt;
      e.idx = N'(m_owner);
      e.y   = '0;
      if (m_gnt) e.y[m_owner] = 1'b1;
      e.to  = m_to;
      return e;
   endfunction

   // Apply inputs for the next edge, advance the model on that edge, queue the expectation
   task automatic drive(input bit e_, input logic [NR-1:0] r_, input bit rl_, input bit rs_);
      bit falling;
      falling = rst_n && !rs_;
      en    = e_;
      req   = r_;
      rel   = rl_;
      rst_n = rs_;
      if (falling) begin
         model_reset();
         if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_out();
      end
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT outputs with the queued expectation once per cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      exp_t a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {gnt_valid, gnt_idx, y, timeout};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got v=%0b idx=%0d y=%b to=%0b want v=%0b idx=%0d y=%b to=%0b",
                     $time, a.v, a.idx, a.y, a.to, e.v, e.idx, e.y, e.to);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      model_reset();

      // Reset state, then idle with enable low
      drive(0, '0, 0, 0);
      drive(0, '0, 0, 0);
      check("reset_valid", 32'(gnt_valid), 0);
      check("reset_idx",   32'(gnt_idx),   0);
      check("reset_y",     32'(y),         0);
      check("reset_to",    32'(timeout),   0);
      drive(0, '0, 0, 1);
      drive(0, 4'b1111, 0, 1);
      check("disabled_no_grant", 32'(gnt_valid), 0);

      // Round robin with all requesting, release right after each grant
      for (int k = 0; k < 5; k++) begin
         drive(1, 4'b1111, 0, 1);
         check("rr_valid", 32'(gnt_valid), 1);
         check("rr_owner", 32'(gnt_idx), 32'(own[k]));
         check("rr_y",     32'(y), 32'(1) << own[k]);
         drive(1, 4'b1111, 1, 1);
         check("rr_gap", 32'(gnt_valid), 0);
         check("rr_gap_y", 32'(y), 0);
      end

      // Owner 1 held to the limit, timeout pulse, re-grant after one idle cycle
      drive(1, 4'b0010, 0, 1);
      for (int k = 1; k < MAX_HOLD; k++) begin
         check("hold_valid", 32'(gnt_valid), 1);
         drive(1, 4'b0010, 0, 1);
      end
      check("hold_valid_last", 32'(gnt_valid), 1);
      drive(1, 4'b0010, 0, 1);
      check("timeout_drop", 32'(gnt_valid), 0);
      check("timeout_pulse", 32'(timeout), 1);
      check("timeout_idx_kept", 32'(gnt_idx), 1);
      drive(1, 4'b0010, 0, 1);
      check("regrant_valid", 32'(gnt_valid), 1);
      check("regrant_idx", 32'(gnt_idx), 1);
      check("timeout_cleared", 32'(timeout), 0);
      drive(1, 4'b0010, 1, 1);

      // Owner 2 drops its request while 0 waits: next owner wraps to 0
      drive(1, 4'b0101, 0, 1);
      check("drop_owner2", 32'(gnt_idx), 2);
      drive(1, 4'b0001, 0, 1);
      check("drop_valid", 32'(gnt_valid), 0);
      check("drop_no_timeout", 32'(timeout), 0);
      drive(1, 4'b0001, 0, 1);
      check("wrap_owner0", 32'(gnt_idx), 0);
      check("wrap_valid", 32'(gnt_valid), 1);
      drive(1, 4'b0001, 1, 1);

      // Disable during a grant, stay idle while disabled, re-enable
      drive(1, 4'b0001, 0, 1);
      drive(0, 4'b0001, 0, 1);
      check("disable_drop", 32'(gnt_valid), 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 4'b0001, 0, 1);
         check("disable_hold_idle", 32'(gnt_valid), 0);
      end
      drive(1, 4'b0001, 0, 1);
      check("reenable_grant", 32'(gnt_valid), 1);
      drive(1, 4'b0001, 1, 1);

      // Release on the same edge as the hold limit: no timeout pulse
      drive(1, 4'b0010, 0, 1);
      for (int k = 1; k < MAX_HOLD; k++) drive(1, 4'b0010, 0, 1);
      drive(1, 4'b0010, 1, 1);
      check("rel_at_limit_valid", 32'(gnt_valid), 0);
      check("rel_at_limit_to", 32'(timeout), 0);

      // Asynchronous reset between edges while a grant is active
      drive(1, 4'b0100, 0, 1);
      @(negedge clk);
      #1;
      check("pre_reset_valid", 32'(gnt_valid), 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_valid", 32'(gnt_valid), 0);
      check("async_y", 32'(y), 0);
      check("async_idx", 32'(gnt_idx), 0);
      drive(1, 4'b1000, 0, 0);
      drive(1, 4'b1000, 0, 0);
      drive(1, 4'b1000, 0, 1);
      check("post_reset_owner3", 32'(gnt_idx), 3);
      check("post_reset_y", 32'(y), 32'h8);
      drive(1, 4'b1000, 1, 1);
      drive(1, 4'b1111, 0, 1);
      check("ptr_wrapped_owner0", 32'(gnt_idx), 0);
      drive(1, 4'b1111, 1, 1);

      // Random traffic with sticky requests so long holds and timeouts occur
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NR; b++) begin
            if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
         end
         drive(($urandom_range(0, 15) != 0), rnd_req,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 399) != 0));
      end

      drive(0, '0, 0, 1);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
